// File: rtl/cpu_pkg.sv
// Shared RV32I definitions: opcodes, funct3/funct7 values, ALU op codes.
// Imported by alu and cpu_top.
package cpu_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  localparam logic [31:0] ILLEGAL_WORD = 32'hdeadbeef;

  typedef enum logic [3:0] {
    ALU_OP_ADD  = 4'b0000,
    ALU_OP_SUB  = 4'b0001,
    ALU_OP_SLL  = 4'b0010,
    ALU_OP_SLT  = 4'b0011,
    ALU_OP_SLTU = 4'b0100,
    ALU_OP_XOR  = 4'b0101,
    ALU_OP_SRL  = 4'b0110,
    ALU_OP_SRA  = 4'b0111,
    ALU_OP_OR   = 4'b1000,
    ALU_OP_AND  = 4'b1001,
    ALU_OP_MUL  = 4'b1010
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_ALU,
    WB_PC4,
    WB_LOAD
  } wb_sel_e;

  function automatic alu_op_e f3_alu(
    input logic [2:0] f3,
    input logic       alt
  );
    alu_op_e op;
    op = ALU_OP_ADD;
    unique case (f3)
      F3_ADD:  op = alt ? ALU_OP_SUB : ALU_OP_ADD;
      F3_SLL:  op = ALU_OP_SLL;
      F3_SLT:  op = ALU_OP_SLT;
      F3_SLTU: op = ALU_OP_SLTU;
      F3_XOR:  op = ALU_OP_XOR;
      F3_SR:   op = alt ? ALU_OP_SRA : ALU_OP_SRL;
      F3_OR:   op = ALU_OP_OR;
      F3_AND:  op = ALU_OP_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu.sv
// RV32I ALU plus MUL (low 32 bits). Ports: op, a, b in; y out.
// Shifts use b[4:0]; all arithmetic wraps modulo 2^32.
module alu
  import cpu_pkg::*;
(
  input  alu_op_e     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  always_comb begin
    y = '0;
    unique case (op)
      ALU_OP_ADD:  y = a + b;
      ALU_OP_SUB:  y = a - b;
      ALU_OP_SLL:  y = a << b[4:0];
      ALU_OP_SLT:  y = {31'b0, $signed(a) < $signed(b)};
      ALU_OP_SLTU: y = {31'b0, a < b};
      ALU_OP_XOR:  y = a ^ b;
      ALU_OP_SRL:  y = a >> b[4:0];
      ALU_OP_SRA:  y = $unsigned($signed(a) >>> b[4:0]);
      ALU_OP_OR:   y = a | b;
      ALU_OP_AND:  y = a & b;
      ALU_OP_MUL:  y = a * b;
      default:     y = a + b;
    endcase
  end

endmodule

// File: rtl/cpu_top.sv
// Single-cycle RV32I + MUL core: decode, regfile, PC, load/store lanes.
// Ports: clk, rst_n, i_mem_addr/i_mem_rdata, d_mem_addr/wdata/wen/rdata.
module cpu_top
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] i_mem_addr,
  input  logic [31:0] i_mem_rdata,
  output logic [31:0] d_mem_addr,
  output logic [31:0] d_mem_wdata,
  output logic [3:0]  d_mem_wen,
  input  logic [31:0] d_mem_rdata
);

  logic [31:0] pc, pc4, next_pc, instr;
  logic [31:0] rf [32];

  logic [6:0]  opcode, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val;

  logic        legal, wb_en;
  logic        is_load, is_store, is_branch;
  logic        is_jal, is_jalr;
  wb_sel_e     wb_sel;
  alu_op_e     alu_op;
  logic [31:0] op_a, op_b, alu_y;

  logic        eq, lt, ltu, taken;
  logic [31:0] ld_shift, ld_data, wb_data;
  logic [15:0] ld_half;
  logic [31:0] st_data;
  logic [3:0]  st_wen;

  assign instr      = i_mem_rdata;
  assign i_mem_addr = pc;
  assign pc4        = pc + 32'd4;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign f3     = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign f7     = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7],
                  instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12],
                  instr[20], instr[30:21], 1'b0};

  assign rs1_val = (rs1 == 5'd0) ? '0 : rf[rs1];
  assign rs2_val = (rs2 == 5'd0) ? '0 : rf[rs2];

  always_comb begin
    legal     = 1'b0;
    wb_en     = 1'b0;
    wb_sel    = WB_ALU;
    alu_op    = ALU_OP_ADD;
    op_a      = rs1_val;
    op_b      = rs2_val;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    unique case (opcode)
      OPC_LUI: begin
        legal = 1'b1;
        wb_en = 1'b1;
        op_a  = '0;
        op_b  = imm_u;
      end
      OPC_AUIPC: begin
        legal = 1'b1;
        wb_en = 1'b1;
        op_a  = pc;
        op_b  = imm_u;
      end
      OPC_JAL: begin
        legal  = 1'b1;
        wb_en  = 1'b1;
        wb_sel = WB_PC4;
        is_jal = 1'b1;
        op_a   = pc;
        op_b   = imm_j;
      end
      OPC_JALR: begin
        legal   = (f3 == 3'b000);
        wb_en   = 1'b1;
        wb_sel  = WB_PC4;
        is_jalr = 1'b1;
        op_b    = imm_i;
      end
      OPC_BRANCH: begin
        legal     = (f3 != 3'b010) && (f3 != 3'b011);
        is_branch = 1'b1;
        op_a      = pc;
        op_b      = imm_b;
      end
      OPC_LOAD: begin
        legal   = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W)
               || (f3 == F3_BU) || (f3 == F3_HU);
        wb_en   = 1'b1;
        wb_sel  = WB_LOAD;
        is_load = 1'b1;
        op_b    = imm_i;
      end
      OPC_STORE: begin
        legal    = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        is_store = 1'b1;
        op_b     = imm_s;
      end
      OPC_OP_IMM: begin
        // Shift-immediates carry funct7 in imm[11:5]; check it.
        unique case (f3)
          F3_SLL:  legal = (f7 == F7_BASE);
          F3_SR:   legal = (f7 == F7_BASE) || (f7 == F7_ALT);
          default: legal = 1'b1;
        endcase
        wb_en  = 1'b1;
        op_b   = imm_i;
        alu_op = f3_alu(f3, (f3 == F3_SR) && instr[30]);
      end
      OPC_OP: begin
        wb_en = 1'b1;
        if (f7 == F7_MUL) begin
          legal  = (f3 == 3'b000);
          alu_op = ALU_OP_MUL;
        end else begin
          legal  = (f7 == F7_BASE)
                || ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SR)));
          alu_op = f3_alu(f3, instr[30]);
        end
      end
      default: ;
    endcase
    // This word decodes as JAL but is reserved as a poison pattern.
    if (instr == ILLEGAL_WORD) legal = 1'b0;
  end

  alu u_alu (
    .op (alu_op),
    .a  (op_a),
    .b  (op_b),
    .y  (alu_y)
  );

  assign eq  = (rs1_val == rs2_val);
  assign lt  = ($signed(rs1_val) < $signed(rs2_val));
  assign ltu = (rs1_val < rs2_val);

  always_comb begin
    taken = 1'b0;
    unique case (f3)
      F3_BEQ:  taken = eq;
      F3_BNE:  taken = !eq;
      F3_BLT:  taken = lt;
      F3_BGE:  taken = !lt;
      F3_BLTU: taken = ltu;
      F3_BGEU: taken = !ltu;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    next_pc = pc4;
    unique case (1'b1)
      legal && is_jal:             next_pc = alu_y;
      legal && is_jalr:            next_pc = {alu_y[31:1], 1'b0};
      legal && is_branch && taken: next_pc = alu_y;
      default: ;
    endcase
  end

  assign ld_shift = d_mem_rdata >> {alu_y[1:0], 3'b000};
  assign ld_half  = alu_y[1] ? d_mem_rdata[31:16] : d_mem_rdata[15:0];

  always_comb begin
    ld_data = d_mem_rdata;
    unique case (f3)
      F3_B:    ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_BU:   ld_data = {24'b0, ld_shift[7:0]};
      F3_HU:   ld_data = {16'b0, ld_half};
      default: ld_data = d_mem_rdata;
    endcase
  end

  // Low address bits beyond the access size are ignored for lanes.
  always_comb begin
    st_wen  = 4'b0000;
    st_data = rs2_val;
    unique case (f3)
      F3_B: begin
        st_wen  = 4'b0001 << alu_y[1:0];
        st_data = rs2_val << {alu_y[1:0], 3'b000};
      end
      F3_H: begin
        st_wen  = alu_y[1] ? 4'b1100 : 4'b0011;
        st_data = alu_y[1] ? {rs2_val[15:0], 16'b0} : rs2_val;
      end
      F3_W:    st_wen = 4'b1111;
      default: st_wen = 4'b0000;
    endcase
  end

  assign d_mem_addr  = alu_y;
  assign d_mem_wdata = st_data;
  assign d_mem_wen   = (rst_n && legal && is_store) ? st_wen : 4'b0000;

  always_comb begin
    wb_data = alu_y;
    unique case (wb_sel)
      WB_PC4:  wb_data = pc4;
      WB_LOAD: wb_data = ld_data;
      default: wb_data = alu_y;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      pc <= next_pc;
      if (legal && wb_en && (rd != 5'd0)) rf[rd] <= wb_data;
    end
  end

endmodule

// File: tb/tb_cpu_top.sv
// Directed bench for cpu_top with store scoreboard.
// Harvard memory models; expected stores queued, popped at negedge.
module tb_cpu_top;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] i_mem_addr, i_mem_rdata;
  logic [31:0] d_mem_addr, d_mem_wdata, d_mem_rdata;
  logic [3:0]  d_mem_wen;

  logic [31:0] imem [1024];
  logic [31:0] dmem [1024];
  logic        mem_clr = 1'b1;
  logic        sb_en = 1'b1;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wen;
    logic [31:0] data;
  } st_t;

  st_t         exp_q [$];
  st_t         e;
  logic [31:0] prog [$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  cpu_top dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_mem_addr  (i_mem_addr),
    .i_mem_rdata (i_mem_rdata),
    .d_mem_addr  (d_mem_addr),
    .d_mem_wdata (d_mem_wdata),
    .d_mem_wen   (d_mem_wen),
    .d_mem_rdata (d_mem_rdata)
  );

  assign i_mem_rdata = imem[i_mem_addr[11:2]];
  assign d_mem_rdata = dmem[d_mem_addr[11:2]];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) dmem[i] <= '0;
    end else if (rst_n) begin
      for (int b = 0; b < 4; b++)
        if (d_mem_wen[b])
          dmem[d_mem_addr[11:2]][8*b +: 8] <= d_mem_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && sb_en && d_mem_wen != 4'b0000) begin
      if (exp_q.size() == 0) begin
        chk("spurious_store", {28'b0, d_mem_wen}, 32'h0);
      end else begin
        e = exp_q.pop_front();
        chk("st_addr", d_mem_addr, e.addr);
        chk("st_wen", {28'b0, d_mem_wen}, {28'b0, e.wen});
        chk("st_data", d_mem_wdata, e.data);
      end
    end
  end

  function automatic logic [31:0] i_t(input int imm, input int rs1,
    input int f3, input int rd, input logic [6:0] op);
    logic [31:0] v, a, f, d;
    v = imm; a = rs1; f = f3; d = rd;
    return {v[11:0], a[4:0], f[2:0], d[4:0], op};
  endfunction

  function automatic logic [31:0] r_t(input int f7, input int rs2,
    input int rs1, input int f3, input int rd);
    logic [31:0] g, b, a, f, d;
    g = f7; b = rs2; a = rs1; f = f3; d = rd;
    return {g[6:0], b[4:0], a[4:0], f[2:0], d[4:0], 7'h33};
  endfunction

  function automatic logic [31:0] s_t(input int imm, input int rs2,
    input int rs1, input int f3);
    logic [31:0] v, b, a, f;
    v = imm; b = rs2; a = rs1; f = f3;
    return {v[11:5], b[4:0], a[4:0], f[2:0], v[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] b_t(input int imm, input int rs2,
    input int rs1, input int f3);
    logic [31:0] v, b, a, f;
    v = imm; b = rs2; a = rs1; f = f3;
    return {v[12], v[10:5], b[4:0], a[4:0], f[2:0],
            v[4:1], v[11], 7'h63};
  endfunction

  function automatic logic [31:0] j_t(input int imm, input int rd);
    logic [31:0] v, d;
    v = imm; d = rd;
    return {v[20], v[10:1], v[11], v[19:12], d[4:0], 7'h6f};
  endfunction

  function automatic logic [31:0] u_t(input int imm, input int rd,
    input logic [6:0] op);
    logic [31:0] v, d;
    v = imm; d = rd;
    return {v[19:0], d[4:0], op};
  endfunction

  function automatic logic [31:0] addi(input int rd, input int rs1,
    input int imm);
    return i_t(imm, rs1, 0, rd, 7'h13);
  endfunction

  function automatic logic [31:0] sw(input int rs2, input int imm);
    return s_t(imm, rs2, 0, 2);
  endfunction

  task automatic expect_st(input logic [31:0] a, input logic [3:0] w,
                           input logic [31:0] d);
    st_t s;
    s.addr = a; s.wen = w; s.data = d;
    exp_q.push_back(s);
  endtask

  // Load prog, hold reset two edges, release away from clock edges.
  task automatic start(input string tag);
    rst_n   = 1'b0;
    mem_clr = 1'b1;
    for (int i = 0; i < 1024; i++) imem[i] = '0;
    for (int i = 0; i < prog.size(); i++) imem[i] = prog[i];
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_rst_pc"}, i_mem_addr, 32'h0);
    chk({tag, "_rst_wen"}, {28'b0, d_mem_wen}, 32'h0);
    @(posedge clk);
    #2;
    mem_clr = 1'b0;
    rst_n   = 1'b1;
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    #1;
    chk(tag, exp_q.size(), 32'h0);
  endtask

  initial begin
    // MUL of negative and positive, stored as word
    prog = '{addi(1, 0, -5), addi(2, 0, 3), r_t(1, 2, 1, 0, 3),
             sw(3, 'h10), j_t(0, 0)};
    exp_q.delete();
    expect_st(32'h10, 4'b1111, 32'hFFFFFFF1);
    start("mul");
    drain("mul_drain", 20);
    chk("mul_mem", dmem[4], 32'hFFFFFFF1);

    // Byte/half stores and sign/zero-extending loads
    prog = '{addi(5, 0, 'hAB), s_t('h21, 5, 0, 0),
             i_t('h21, 0, 0, 6, 7'h03), i_t('h21, 0, 4, 7, 7'h03),
             sw(6, 'h40), sw(7, 'h44), addi(8, 0, -2),
             s_t('h52, 8, 0, 1), i_t('h52, 0, 1, 9, 7'h03),
             i_t('h52, 0, 5, 10, 7'h03), sw(9, 'h60), sw(10, 'h64),
             sw(5, 'h73), s_t('h71, 5, 0, 1), j_t(0, 0)};
    exp_q.delete();
    expect_st(32'h21, 4'b0010, 32'h0000AB00);
    expect_st(32'h40, 4'b1111, 32'hFFFFFFAB);
    expect_st(32'h44, 4'b1111, 32'h000000AB);
    expect_st(32'h52, 4'b1100, 32'hFFFE0000);
    expect_st(32'h60, 4'b1111, 32'hFFFFFFFE);
    expect_st(32'h64, 4'b1111, 32'h0000FFFE);
    expect_st(32'h73, 4'b1111, 32'h000000AB);
    expect_st(32'h71, 4'b0011, 32'h000000AB);
    start("ldst");
    drain("ldst_drain", 40);
    chk("ldst_sb_mem", dmem[8], 32'h0000AB00);

    // Shifts, compares, SUB, LUI/AUIPC, XORI
    prog = '{addi(1, 0, -16), i_t('h402, 1, 5, 2, 7'h13),
             i_t(28, 1, 5, 3, 7'h13), r_t(0, 0, 1, 2, 4),
             r_t(0, 1, 0, 3, 5), addi(6, 0, 33), r_t(0, 6, 3, 1, 7),
             r_t('h20, 1, 0, 0, 8), u_t('h12345, 9, 7'h37),
             u_t(1, 10, 7'h17), i_t('hFF, 1, 4, 11, 7'h13),
             r_t('h20, 6, 1, 5, 12)};
    for (int k = 2; k <= 12; k++) prog.push_back(sw(k, 'h100 + 4*(k-2)));
    prog.push_back(j_t(0, 0));
    exp_q.delete();
    expect_st(32'h100, 4'hF, 32'hFFFFFFFC);
    expect_st(32'h104, 4'hF, 32'h0000000F);
    expect_st(32'h108, 4'hF, 32'h00000001);
    expect_st(32'h10C, 4'hF, 32'h00000001);
    expect_st(32'h110, 4'hF, 32'h00000021);
    expect_st(32'h114, 4'hF, 32'h0000001E);
    expect_st(32'h118, 4'hF, 32'h00000010);
    expect_st(32'h11C, 4'hF, 32'h12345000);
    expect_st(32'h120, 4'hF, 32'h00001024);
    expect_st(32'h124, 4'hF, 32'hFFFFFF0F);
    expect_st(32'h128, 4'hF, 32'hFFFFFFF8);
    start("alu");
    drain("alu_drain", 60);

    // Counted BNE loop plus JAL/JALR call-return
    prog = '{addi(1, 0, 0), addi(2, 0, 5), addi(1, 1, 1),
             b_t(-4, 2, 1, 1), j_t(20, 5), sw(1, 'h80), sw(5, 'h84),
             sw(6, 'h88), j_t(0, 0), addi(6, 0, 7),
             i_t(1, 5, 0, 0, 7'h67)};
    exp_q.delete();
    expect_st(32'h80, 4'hF, 32'd5);
    expect_st(32'h84, 4'hF, 32'h14);
    expect_st(32'h88, 4'hF, 32'd7);
    start("call");
    drain("call_drain", 60);

    // Illegal word, ECALL and MULH all act as NOPs
    prog = '{addi(1, 0, 9), addi(2, 0, 2), 32'hdeadbeef, 32'h00000073,
             r_t(1, 2, 1, 1, 1), sw(1, 'h90), sw(29, 'h94), j_t(0, 0)};
    exp_q.delete();
    expect_st(32'h90, 4'hF, 32'd9);
    expect_st(32'h94, 4'hF, 32'd0);
    start("nop");
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      chk("nop_pc_seq", i_mem_addr, 32'(4 * k));
      if (k == 2) chk("nop_bad_wen", {28'b0, d_mem_wen}, 32'h0);
    end
    drain("nop_drain", 20);

    // Reset pulled mid-loop: immediate PC/wen reset, registers cleared
    prog = '{sw(1, 'hA0), addi(1, 1, 1), j_t(-4, 0)};
    exp_q.delete();
    expect_st(32'hA0, 4'hF, 32'd0);
    start("rst");
    drain("rst_first", 10);
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_pc", i_mem_addr, 32'h0);
    chk("rst_mid_wen", {28'b0, d_mem_wen}, 32'h0);
    expect_st(32'hA0, 4'hF, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_pc", i_mem_addr, 32'h0);
    #1;
    rst_n = 1'b1;
    drain("rst_rerun", 10);
    chk("rst_rerun_mem", dmem[40], 32'd0);

    // Copy {1,3,2} to 0x300, bubble sort descending, marker at 0x400
    prog = '{addi(20, 0, 1), sw(20, 'h200), addi(20, 0, 3),
             sw(20, 'h204), addi(20, 0, 2), sw(20, 'h208),
             addi(10, 0, 'h200), addi(11, 0, 'h300), addi(12, 0, 3),
             i_t(0, 10, 2, 13, 7'h03), s_t(0, 13, 11, 2),
             addi(10, 10, 4), addi(11, 11, 4), addi(12, 12, -1),
             b_t(-20, 0, 12, 1),
             addi(14, 0, 2), addi(11, 0, 'h300), addi(15, 14, 0),
             i_t(0, 11, 2, 16, 7'h03), i_t(4, 11, 2, 17, 7'h03),
             b_t(12, 17, 16, 5), s_t(0, 17, 11, 2), s_t(4, 16, 11, 2),
             addi(11, 11, 4), addi(15, 15, -1), b_t(-28, 0, 15, 1),
             addi(14, 14, -1), b_t(-44, 0, 14, 1),
             addi(18, 0, 'h42), sw(18, 'h400), j_t(0, 0)};
    exp_q.delete();
    sb_en = 1'b0;
    start("sort");
    for (int n = 0; n < 10000 && dmem[256] !== 32'h42; n++)
      @(negedge clk);
    chk("sort_marker", dmem[256], 32'h42);
    chk("sort_m0", dmem[192], 32'd3);
    chk("sort_m1", dmem[193], 32'd2);
    chk("sort_m2", dmem[194], 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_top.md
CPU_TOP -- requirements
Module: cpu_top

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 i_mem_addr  output  32  byte address of current instruction (equals PC).
REQ-005 i_mem_rdata  input  32  instruction word at i_mem_addr, combinational, same cycle.
REQ-006 d_mem_addr  output  32  data byte address (rs1 + imm), unaligned low bits preserved.
REQ-007 d_mem_wdata  output  32  store data, shifted into the addressed byte lanes.
REQ-008 d_mem_wen  output  4  per-byte write enables, bit n selects byte lane n; 4'b0000 means no write.
REQ-009 d_mem_rdata  input  32  word containing d_mem_addr, combinational, same cycle.

Function
REQ-010 Core SHALL be single-cycle RV32I: one instruction fetched, executed and committed per rising clk edge while rst_n is high.
REQ-011 Core SHALL implement LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LB/LH/LW/LBU/LHU, SB/SH/SW, all OP-IMM and OP instructions, plus MUL (funct7 0000001, funct3 000, low 32 bits of product).
REQ-012 x0 SHALL read as 0; writes to x0 SHALL be discarded; register file 32x32, two combinational reads, one write per edge.
REQ-013 Next PC SHALL be PC+4, the branch target PC+imm_B when taken, PC+imm_J for JAL, or (rs1+imm_I) with bit 0 cleared for JALR; JAL/JALR SHALL write PC+4 to rd.
REQ-014 Shift amounts SHALL use the low 5 bits only; SRA/SRAI SHALL be arithmetic; SLT is signed and SLTU unsigned; all arithmetic SHALL wrap modulo 2^32.
REQ-015 Store enables SHALL be: SW 4'b1111; SH 4'b0011 or 4'b1100 chosen by addr[1]; SB 4'b0001 shifted left by addr[1:0].
REQ-016 d_mem_wdata SHALL carry rs2 shifted left by 8*addr[1:0] for SB, by 16*addr[1] for SH, and unshifted for SW.
REQ-017 Misaligned SH/SW SHALL ignore the offending low address bits for lane selection; no trap.
REQ-018 Loads SHALL extract the byte or halfword from d_mem_rdata at lane addr[1:0] (halfwords at lane addr[1]), sign-extending for LB/LH and zero-extending for LBU/LHU; rd SHALL be written at the same edge.
REQ-019 d_mem_wen SHALL be 4'b0000 for every non-store instruction; d_mem_addr SHALL equal the ALU result for non-memory instructions.
REQ-020 FENCE, ECALL, EBREAK, unsupported funct7 0000001 encodings and illegal opcodes SHALL execute as NOP (PC+4, no register or memory write).
REQ-021 Reading an instruction of 32'hdeadbeef SHALL be treated as illegal, i.e. as a NOP.

Reset
REQ-022 While rst_n is low: PC = RESET_PC, i_mem_addr = RESET_PC, d_mem_wen = 4'b0000, and all registers x1..x31 cleared to 0.
REQ-023 Reset assertion mid-program SHALL abort the current instruction immediately with no register or memory commit.
REQ-024 The first instruction SHALL commit at the first rising edge after rst_n deasserts.

Structure
REQ-025 Shared package cpu_pkg SHALL hold the opcode constants, funct3 constants and 4-bit ALU op codes (including ALU_OP_MUL = 4'b1010).
REQ-026 One sub-module, alu, SHALL implement all ALU ops including MUL; decode, register file, PC and load/store alignment SHALL reside in cpu_top.

Verification
REQ-027 Bubble-sort-copy program storing {3,2,1} to 0x300..0x308, then 0x42 to 0x400 -> mem[0x300/4..+2] = 3,2,1 and marker 0x42 within 10000 cycles.
REQ-028 ADDI x1,x0,-5; ADDI x2,x0,3; MUL x3,x1,x2; SW x3,0x10(x0) -> mem[4] = 0xFFFFFFF1, wen = 4'b1111.
REQ-029 x5=0x000000AB; SB x5,0x21(x0) -> wen = 4'b0010, wdata[15:8] = 0xAB; a subsequent LB from 0x21 -> rd = 0xFFFFFFAB, LBU -> 0x000000AB.
REQ-030 Count loop with BNE back-branch 5 iterations and JAL/JALR call-return -> final counter 5, link = call PC+4, PC resumes after the call.
REQ-031 rst_n pulled low mid-loop for 2 cycles -> i_mem_addr = 0 and wen = 0 immediately, all registers 0, program reruns from 0.
REQ-032 Illegal word 32'hdeadbeef at 0x8 -> no writes, PC advances to 0xC.
